// File: rtl/drcp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | drcp_pkg : shared constants and types for the L1 TCM region     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package drcp_pkg;

    localparam int unsigned L1RAM_SIZE   = 32'h0000_4000;
    localparam int          STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_CORE,
        RSP_EXT,
        RSP_EXT_ERR
    } tcm_rsp_owner_e;

endpackage
`default_nettype wire

// File: rtl/l1_tcm_arbiter_starve_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tcm_starve_cnt : saturating wait counter with force flag        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tcm_starve_cnt
    import drcp_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_o
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/l1_tcm_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | l1_tcm_arbiter : core/external arbiter for the single-port TCM  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module l1_tcm_arbiter
    import drcp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    c_req_i,
    input  logic                    c_we_i,
    input  logic [ADDR_WIDTH-1:0]   c_addr_i,
    input  logic [DATA_WIDTH-1:0]   c_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] c_be_i,
    output logic                    c_gnt_o,
    output logic                    c_rvalid_o,
    output logic [DATA_WIDTH-1:0]   c_rdata_o,
    input  logic                    e_req_i,
    input  logic                    e_we_i,
    input  logic [ADDR_WIDTH-1:0]   e_addr_i,
    input  logic [DATA_WIDTH-1:0]   e_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] e_be_i,
    output logic                    e_gnt_o,
    output logic                    e_rvalid_o,
    output logic                    e_err_o,
    output logic [DATA_WIDTH-1:0]   e_rdata_o,
    output logic                    m_en_o,
    output logic                    m_we_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i
);

    logic           starve_force;
    logic           e_oor;
    logic           owner_rd_d, owner_rd_q;
    tcm_rsp_owner_e owner_d, owner_q;

    tcm_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (e_req_i & ~e_gnt_o),
        .clr_i   (~e_req_i | e_gnt_o),
        .force_o (starve_force)
    );

    always_comb begin
        e_oor      = (32'(e_addr_i) >= L1RAM_SIZE) || (e_addr_i[1:0] != 2'b00);
        e_gnt_o    = e_req_i & (~c_req_i | starve_force);
        c_gnt_o    = c_req_i & ~e_gnt_o;
        m_en_o     = c_gnt_o | (e_gnt_o & ~e_oor);
        m_we_o     = c_we_i;
        m_addr_o   = c_addr_i;
        m_wdata_o  = c_wdata_i;
        m_be_o     = c_be_i;
        owner_d    = RSP_NONE;
        owner_rd_d = 1'b0;
        if (e_gnt_o) begin
            m_we_o     = e_we_i;
            m_addr_o   = e_addr_i;
            m_wdata_o  = e_wdata_i;
            m_be_o     = e_be_i;
            owner_d    = e_oor ? RSP_EXT_ERR : RSP_EXT;
            owner_rd_d = ~e_we_i & ~e_oor;
        end else if (c_gnt_o) begin
            owner_d    = RSP_CORE;
            owner_rd_d = ~c_we_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q    <= RSP_NONE;
            owner_rd_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            owner_rd_q <= owner_rd_d;
        end
    end

    // Read data is only forwarded to the owner of a read; writes and errors return zero.
    assign c_rvalid_o = (owner_q == RSP_CORE);
    assign e_rvalid_o = (owner_q == RSP_EXT) || (owner_q == RSP_EXT_ERR);
    assign e_err_o    = (owner_q == RSP_EXT_ERR);
    assign c_rdata_o  = (c_rvalid_o && owner_rd_q) ? m_rdata_i : '0;
    assign e_rdata_o  = ((owner_q == RSP_EXT) && owner_rd_q) ? m_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_l1_tcm_arbiter.sv
`default_nettype none
// Scoreboard bench for l1_tcm_arbiter: directed vectors, queued expected responses.
module tb_l1_tcm_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        c_req_i, c_we_i, e_req_i, e_we_i;
    logic [15:0] c_addr_i, e_addr_i;
    logic [31:0] c_wdata_i, e_wdata_i;
    logic [3:0]  c_be_i, e_be_i;
    logic        c_gnt_o, c_rvalid_o, e_gnt_o, e_rvalid_o, e_err_o;
    logic [31:0] c_rdata_o, e_rdata_o;
    logic        m_en_o, m_we_o;
    logic [15:0] m_addr_o;
    logic [31:0] m_wdata_o, m_rdata_i;
    logic [3:0]  m_be_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] cq[$];
    logic [32:0] eq[$];
    logic [31:0] mem [logic [15:0]];

    always #5 clk = ~clk;

    l1_tcm_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .c_req_i    (c_req_i),
        .c_we_i     (c_we_i),
        .c_addr_i   (c_addr_i),
        .c_wdata_i  (c_wdata_i),
        .c_be_i     (c_be_i),
        .c_gnt_o    (c_gnt_o),
        .c_rvalid_o (c_rvalid_o),
        .c_rdata_o  (c_rdata_o),
        .e_req_i    (e_req_i),
        .e_we_i     (e_we_i),
        .e_addr_i   (e_addr_i),
        .e_wdata_i  (e_wdata_i),
        .e_be_i     (e_be_i),
        .e_gnt_o    (e_gnt_o),
        .e_rvalid_o (e_rvalid_o),
        .e_err_o    (e_err_o),
        .e_rdata_o  (e_rdata_o),
        .m_en_o     (m_en_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_be_o     (m_be_o),
        .m_rdata_i  (m_rdata_i)
    );

    // TCM model: registered read, byte-enabled write, junk on non-read cycles.
    always @(posedge clk) begin
        logic [31:0] w;
        if (m_en_o && !m_we_o) begin
            m_rdata_i <= mem.exists(m_addr_o) ? mem[m_addr_o] : 32'h0;
        end else begin
            m_rdata_i <= 32'hCAFE_F00D;
        end
        if (m_en_o && m_we_o) begin
            w = mem.exists(m_addr_o) ? mem[m_addr_o] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (m_be_o[b]) w[8*b +: 8] = m_wdata_o[8*b +: 8];
            end
            mem[m_addr_o] = w;
        end
    end

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a port presents a response.
    always @(negedge clk) begin
        logic [32:0] ee;
        if (rst_i) begin
            chk("rvalid_in_reset", {31'b0, c_rvalid_o, e_rvalid_o}, 33'h0);
        end else begin
            if (c_rvalid_o) begin
                if (cq.size() == 0) chk("c_unexpected_rvalid", 33'h1, 33'h0);
                else chk("c_rdata", {1'b0, c_rdata_o}, {1'b0, cq.pop_front()});
            end else begin
                chk("c_rdata_idle", {1'b0, c_rdata_o}, 33'h0);
            end
            if (e_rvalid_o) begin
                if (eq.size() == 0) chk("e_unexpected_rvalid", 33'h1, 33'h0);
                else begin
                    ee = eq.pop_front();
                    chk("e_err_rdata", {e_err_o, e_rdata_o}, ee);
                end
            end else begin
                chk("e_rdata_idle", {e_err_o, e_rdata_o}, 33'h0);
            end
        end
    end

    task automatic set_c(input logic r, input logic we, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        c_req_i = r; c_we_i = we; c_addr_i = a; c_wdata_i = d; c_be_i = be;
    endtask

    task automatic set_e(input logic r, input logic we, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        e_req_i = r; e_we_i = we; e_addr_i = a; e_wdata_i = d; e_be_i = be;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string nm, input logic cg, input logic eg, input logic men);
        #3;
        chk(nm, {30'b0, c_gnt_o, e_gnt_o, m_en_o}, {30'b0, cg, eg, men});
    endtask

    initial begin
        mem[16'h0010] = 32'hDEAD_BEEF;
        mem[16'h0020] = 32'h1111_2222;
        mem[16'h0024] = 32'h3333_4444;
        rst_i = 1'b1;
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(0, 0, 16'h0, 32'h0, 4'h0);
        repeat (2) next_cycle();
        chk("reset_state", {27'b0, c_rvalid_o, e_rvalid_o, e_err_o, m_en_o, c_gnt_o, e_gnt_o},
            33'h0);
        chk("reset_rdata", {1'b0, c_rdata_o | e_rdata_o}, 33'h0);

        // Core read released in the same cycle as reset.
        rst_i = 1'b0;
        set_c(1, 0, 16'h0010, 32'h0, 4'hF);
        cq.push_back(32'hDEAD_BEEF);
        chk_gnt("core_read_gnt", 1, 0, 1);
        chk("core_read_addr", {17'b0, m_addr_o}, 33'h0010);

        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(1, 1, 16'h0100, 32'h1234_5678, 4'b0011);
        eq.push_back({1'b0, 32'h0});
        chk_gnt("ext_write_gnt", 0, 1, 1);
        chk("ext_write_we_be", {28'b0, m_we_o, m_be_o}, {28'b0, 1'b1, 4'b0011});

        next_cycle();
        set_e(0, 0, 16'h0, 32'h0, 4'h0);
        chk_gnt("idle_gnt", 0, 0, 0);

        // Both requesting: external wins every STARVE_MAX+1 cycles.
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            set_c(1, 0, 16'h0020, 32'h0, 4'hF);
            set_e(1, 0, 16'h0024, 32'h0, 4'hF);
            if (i == 5 || i == 10) begin
                eq.push_back({1'b0, 32'h3333_4444});
                chk_gnt($sformatf("starve_c%0d", i), 0, 1, 1);
            end else begin
                cq.push_back(32'h1111_2222);
                chk_gnt($sformatf("starve_c%0d", i), 1, 0, 1);
            end
        end

        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(1, 0, 16'h4000, 32'h0, 4'hF);
        eq.push_back({1'b1, 32'h0});
        chk_gnt("oor_size_gnt", 0, 1, 0);
        next_cycle();
        set_e(1, 0, 16'h0002, 32'h0, 4'hF);
        eq.push_back({1'b1, 32'h0});
        chk_gnt("oor_align_gnt", 0, 1, 0);

        // Alternating ports back-to-back; 0x100 holds the earlier partial write.
        next_cycle();
        set_e(0, 0, 16'h0, 32'h0, 4'h0);
        set_c(1, 0, 16'h0100, 32'h0, 4'hF);
        cq.push_back(32'h0000_5678);
        chk_gnt("alt_core_rd", 1, 0, 1);
        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(1, 0, 16'h0010, 32'h0, 4'hF);
        eq.push_back({1'b0, 32'hDEAD_BEEF});
        chk_gnt("alt_ext_rd", 0, 1, 1);
        next_cycle();
        set_e(0, 0, 16'h0, 32'h0, 4'h0);
        set_c(1, 1, 16'h0020, 32'hAAAA_5555, 4'hF);
        cq.push_back(32'h0);
        chk_gnt("alt_core_wr", 1, 0, 1);
        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(1, 0, 16'h0020, 32'h0, 4'hF);
        eq.push_back({1'b0, 32'hAAAA_5555});
        chk_gnt("alt_ext_rd2", 0, 1, 1);

        // External drops mid-wait: the count restarts from zero.
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            set_c(1, 0, 16'h0020, 32'h0, 4'hF);
            set_e(i != 4, 0, 16'h0024, 32'h0, 4'hF);
            if (i == 9) begin
                eq.push_back({1'b0, 32'h3333_4444});
                chk_gnt($sformatf("midwait_c%0d", i), 0, 1, 1);
            end else begin
                cq.push_back(32'hAAAA_5555);
                chk_gnt($sformatf("midwait_c%0d", i), 1, 0, 1);
            end
        end

        // Reset before the external response is delivered: it is dropped.
        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        set_e(1, 0, 16'h0024, 32'h0, 4'hF);
        chk_gnt("pre_reset_gnt", 0, 1, 1);
        #2;
        rst_i = 1'b1;
        set_e(0, 0, 16'h0, 32'h0, 4'h0);
        next_cycle();
        chk("reset_drop_rvalid", {32'b0, e_rvalid_o}, 33'h0);
        next_cycle();
        rst_i = 1'b0;
        set_c(1, 0, 16'h0010, 32'h0, 4'hF);
        cq.push_back(32'hDEAD_BEEF);
        chk_gnt("post_reset_gnt", 1, 0, 1);
        next_cycle();
        set_c(0, 0, 16'h0, 32'h0, 4'h0);
        #3;
        chk("post_reset_rvalid", {31'b0, c_rvalid_o, e_rvalid_o}, 33'h2);

        repeat (3) next_cycle();
        chk("scoreboard_drained", 33'(cq.size() + eq.size()), 33'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
